// File: rtl/mod_mul_barrett_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mod_mul_barrett_pipe                                            |
// | Purpose  : 4-stage multi-lane Barrett modular multiplier, out = a*b mod Q, |
// |            valid/ready flow control; MODMUL_RANGE_CHK_EN adds out_err.    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module mod_mul_barrett_pipe #(
  parameter int unsigned W     = 12,
  parameter int unsigned Q     = 3329,
  parameter int unsigned K     = 2*W,
  parameter int unsigned LANES = 1,
  parameter int unsigned TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 r,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LANES*W-1:0]   in_a,
  input  logic [LANES*W-1:0]   in_b,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LANES*W-1:0]   out_data,
  output logic [TAG_W-1:0]     out_tag,
  output logic [LANES-1:0]     out_err
);

  // Wide enough for the full c*MU product, so m is exact before truncation.
  localparam int unsigned    PW    = 2*W + K + 1;
  localparam logic [PW-1:0]  TWO_K = PW'(1) << K;
  localparam logic [PW-1:0]  MU    = TWO_K / PW'(Q);
  localparam logic [2*W-1:0] Q_C   = (2*W)'(Q);
  localparam logic [W+1:0]   Q_X   = (W+2)'(Q);

  logic                      w_en;
  logic                      r_v1, r_v2, r_v3, r_v4;
  logic [TAG_W-1:0]          r_t1, r_t2, r_t3, r_t4;
  logic [LANES*2*W-1:0]      w_c, r_s1_c, r_s2_c;
  logic [LANES*2*W-1:0]      w_m, r_s2_m;
  logic [LANES*(W+2)-1:0]    w_x, r_s3_x;
  logic [LANES*W-1:0]        w_y, r_s4_y;

  assign w_en      = !r_v4 || out_ready;
  assign in_ready  = w_en;
  assign out_valid = r_v4;
  assign out_data  = r_s4_y;
  assign out_tag   = r_t4;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [W-1:0]  w_a, w_b;
    logic [PW-1:0] w_cext;
    logic [W+1:0]  w_x0, w_x1;

    assign w_a = in_a[gi*W +: W];
    assign w_b = in_b[gi*W +: W];
    assign w_c[gi*2*W +: 2*W] = (2*W)'(w_a) * (2*W)'(w_b);

    assign w_cext = PW'(r_s1_c[gi*2*W +: 2*W]);
    assign w_m[gi*2*W +: 2*W] = (2*W)'((w_cext * MU) >> K);

    // Barrett estimate undershoots by at most 2, so x < 3Q fits in W+2 bits.
    assign w_x[gi*(W+2) +: W+2] =
      (W+2)'(r_s2_c[gi*2*W +: 2*W] - Q_C * r_s2_m[gi*2*W +: 2*W]);

    assign w_x0 = r_s3_x[gi*(W+2) +: W+2];
    assign w_x1 = (w_x0 >= Q_X) ? w_x0 - Q_X : w_x0;
    assign w_y[gi*W +: W] = W'((w_x1 >= Q_X) ? w_x1 - Q_X : w_x1);
  end

  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      r_v1   <= 1'b0;
      r_v2   <= 1'b0;
      r_v3   <= 1'b0;
      r_v4   <= 1'b0;
      r_t1   <= '0;
      r_t2   <= '0;
      r_t3   <= '0;
      r_t4   <= '0;
      r_s1_c <= '0;
      r_s2_c <= '0;
      r_s2_m <= '0;
      r_s3_x <= '0;
      r_s4_y <= '0;
    end else if (w_en) begin
      r_v1   <= in_valid;
      r_v2   <= r_v1;
      r_v3   <= r_v2;
      r_v4   <= r_v3;
      r_t1   <= in_tag;
      r_t2   <= r_t1;
      r_t3   <= r_t2;
      r_t4   <= r_t3;
      r_s1_c <= w_c;
      r_s2_c <= r_s1_c;
      r_s2_m <= w_m;
      r_s3_x <= w_x;
      r_s4_y <= w_y;
    end
  end

`ifdef MODMUL_RANGE_CHK_EN
  localparam logic [W-1:0] Q_W = W'(Q);

  logic [LANES-1:0] w_err, r_e1, r_e2, r_e3, r_e4;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_err
    assign w_err[gi] = (in_a[gi*W +: W] >= Q_W) || (in_b[gi*W +: W] >= Q_W);
  end

  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      r_e1 <= '0;
      r_e2 <= '0;
      r_e3 <= '0;
      r_e4 <= '0;
    end else if (w_en) begin
      r_e1 <= w_err;
      r_e2 <= r_e1;
      r_e3 <= r_e2;
      r_e4 <= r_e3;
    end
  end

  assign out_err = r_e4;
`else
  assign out_err = '0;
`endif

endmodule
`default_nettype wire
